// File: rtl/reorder_buffer_mc.sv
// reorder_buffer_mc: multi-channel in-order reorder buffer.
// Allocates in program order, accepts NUM_WB writebacks per cycle and retires one
// entry per cycle (register write, branch resolution or store release). A branch
// whose outcome differs from its prediction flushes the buffer and redirects fetch.
// Optional feature macro: ROB_FWD_EN -- when defined, operand lookups also see
// same-cycle writebacks; when undefined they reflect stored state only.
module reorder_buffer_mc #(
  parameter int ROB_WIDTH   = 4,
  parameter int NUM_WB      = 2,
  parameter int FULL_MARGIN = 2
) (
  input  logic                        clockIn,
  input  logic                        resetIn,
  output logic                        clear,
  output logic [31:0]                 newPc,
  input  logic [NUM_WB-1:0]           wbValid,
  input  logic [NUM_WB*ROB_WIDTH-1:0] wbRobIndex,
  input  logic [NUM_WB*32-1:0]        wbValue,
  input  logic                        addValid,
  input  logic [1:0]                  addType,
  input  logic                        addReady,
  input  logic [31:0]                 addValue,
  input  logic                        addJump,
  input  logic [4:0]                  addDest,
  input  logic [31:0]                 addAddr,
  output logic                        full,
  output logic [ROB_WIDTH-1:0]        next,
  output logic [ROB_WIDTH-1:0]        robBeginId,
  output logic                        storeCommit,
  output logic [ROB_WIDTH-1:0]        storeRobId,
  output logic                        regUpdateValid,
  output logic [4:0]                  regUpdateDest,
  output logic [31:0]                 regValue,
  output logic [ROB_WIDTH-1:0]        regUpdateRobId,
  input  logic [ROB_WIDTH-1:0]        rs1Dep,
  input  logic [ROB_WIDTH-1:0]        rs2Dep,
  output logic                        rs1Ready,
  output logic                        rs2Ready,
  output logic [31:0]                 rs1Value,
  output logic [31:0]                 rs2Value
);

  localparam int ROB_SIZE = 2 ** ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] SIZE_C = (ROB_WIDTH + 1)'(ROB_SIZE);
  localparam logic [ROB_WIDTH:0] FULL_C = (ROB_WIDTH + 1)'(ROB_SIZE - FULL_MARGIN);

  typedef logic [ROB_WIDTH-1:0] idx_t;

  typedef enum logic [1:0] {
    ROB_REG    = 2'b00,
    ROB_BRANCH = 2'b01,
    ROB_STORE  = 2'b10,
    ROB_RSVD   = 2'b11
  } rob_type_e;

  typedef struct packed {
    rob_type_e   kind;
    logic        jump;
    logic [4:0]  dest;
    logic [31:0] value;
    logic [31:0] addr;
  } rob_entry_t;

  // Entry status bits (reset) and entry payload (no reset)
  logic [ROB_SIZE-1:0] valid_q, valid_d;
  logic [ROB_SIZE-1:0] ready_q, ready_d;
  rob_entry_t          entry_q [ROB_SIZE];
  rob_entry_t          entry_d [ROB_SIZE];

  // Pointers and occupancy
  idx_t               head_q, head_d;
  idx_t               tail_q, tail_d;
  logic [ROB_WIDTH:0] count_q, count_d;

  // Registered outputs
  logic        clear_q, clear_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        reg_update_valid_q, reg_update_valid_d;
  logic [4:0]  reg_update_dest_q, reg_update_dest_d;
  logic [31:0] reg_value_q, reg_value_d;
  idx_t        reg_update_rob_id_q, reg_update_rob_id_d;
  logic        store_commit_q, store_commit_d;
  idx_t        store_rob_id_q, store_rob_id_d;

  // Per-cycle decisions
  logic do_alloc;
  logic do_retire;
  logic mispredict;
  idx_t wb_idx;

  // Next-state: writebacks, in-order retire, allocation and mispredict flush
  always_comb begin
    // NOTE: every variable gets a default first so no path through this block leaves one unassigned (no latches).
    valid_d             = valid_q;
    ready_d             = ready_q;
    entry_d             = entry_q;
    head_d              = head_q;
    tail_d              = tail_q;
    count_d             = count_q;
    clear_d             = 1'b0;
    new_pc_d            = new_pc_q;
    reg_update_valid_d  = 1'b0;
    reg_update_dest_d   = reg_update_dest_q;
    reg_value_d         = reg_value_q;
    reg_update_rob_id_d = reg_update_rob_id_q;
    store_commit_d      = 1'b0;
    store_rob_id_d      = store_rob_id_q;
    do_alloc            = 1'b0;
    do_retire           = 1'b0;
    mispredict          = 1'b0;
    wb_idx              = '0;

    // Nothing moves during the flush cycle.
    if (!clear_q) begin
      // Ascending channel order: the highest channel writing an index wins.
      for (int k = 0; k < NUM_WB; k++) begin
        wb_idx = wbRobIndex[k*ROB_WIDTH +: ROB_WIDTH];
        if (wbValid[k] && valid_q[wb_idx]) begin
          entry_d[wb_idx].value = wbValue[k*32 +: 32];
          ready_d[wb_idx]       = 1'b1;
        end
      end

      // Retire looks at stored readiness only, so a writeback retires next cycle at the earliest.
      if (valid_q[head_q] && ready_q[head_q]) begin
        do_retire       = 1'b1;
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
        case (entry_q[head_q].kind)
          ROB_BRANCH: begin
            if (entry_q[head_q].value[0] != entry_q[head_q].jump) begin
              mispredict = 1'b1;
            end
          end
          ROB_STORE: begin
            store_commit_d = 1'b1;
            store_rob_id_d = head_q;
          end
          default: begin
            reg_update_valid_d  = 1'b1;
            reg_update_dest_d   = entry_q[head_q].dest;
            reg_value_d         = entry_q[head_q].value;
            reg_update_rob_id_d = head_q;
          end
        endcase
      end

      // A mispredict in the same cycle discards the incoming allocation.
      do_alloc = addValid && (count_q < SIZE_C) && !mispredict;
      if (do_alloc) begin
        valid_d[tail_q] = 1'b1;
        ready_d[tail_q] = addReady;
        // The reserved type behaves as a register write to x0.
        entry_d[tail_q] = '{
          kind:  (addType == 2'b11) ? ROB_REG : rob_type_e'(addType),
          jump:  addJump,
          dest:  (addType == 2'b11) ? 5'd0 : addDest,
          value: addValue,
          addr:  addAddr
        };
        tail_d = tail_q + 1'b1;
      end

      case ({do_alloc, do_retire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      if (mispredict) begin
        valid_d  = '0;
        head_d   = '0;
        tail_d   = '0;
        count_d  = '0;
        clear_d  = 1'b1;
        new_pc_d = entry_q[head_q].addr;
      end
    end
  end

  // Control state and registered outputs, asynchronously cleared
  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      valid_q             <= '0;
      ready_q             <= '0;
      head_q              <= '0;
      tail_q              <= '0;
      count_q             <= '0;
      clear_q             <= 1'b0;
      new_pc_q            <= '0;
      reg_update_valid_q  <= 1'b0;
      reg_update_dest_q   <= '0;
      reg_value_q         <= '0;
      reg_update_rob_id_q <= '0;
      store_commit_q      <= 1'b0;
      store_rob_id_q      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      valid_q             <= valid_d;
      ready_q             <= ready_d;
      head_q              <= head_d;
      tail_q              <= tail_d;
      count_q             <= count_d;
      clear_q             <= clear_d;
      new_pc_q            <= new_pc_d;
      reg_update_valid_q  <= reg_update_valid_d;
      reg_update_dest_q   <= reg_update_dest_d;
      reg_value_q         <= reg_value_d;
      reg_update_rob_id_q <= reg_update_rob_id_d;
      store_commit_q      <= store_commit_d;
      store_rob_id_q      <= store_rob_id_d;
    end
  end

  // Entry payload storage
  always_ff @(posedge clockIn) begin
    // NOTE: payload is not reset; the valid bits gate every use of it, so the array can map to plain RAM.
    entry_q <= entry_d;
  end

  // Operand tag lookup for the two source ports
  idx_t        lk_dep   [2];
  logic        lk_ready [2];
  logic [31:0] lk_value [2];

  assign lk_dep[0] = rs1Dep;
  assign lk_dep[1] = rs2Dep;

  // Stored-state lookup, optionally overlaid with same-cycle writebacks
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      lk_ready[p] = valid_q[lk_dep[p]] & ready_q[lk_dep[p]];
      lk_value[p] = entry_q[lk_dep[p]].value;
`ifdef ROB_FWD_EN
      for (int k = 0; k < NUM_WB; k++) begin
        if (wbValid[k] && !clear_q && valid_q[lk_dep[p]] &&
            (wbRobIndex[k*ROB_WIDTH +: ROB_WIDTH] == lk_dep[p])) begin
          lk_ready[p] = 1'b1;
          lk_value[p] = wbValue[k*32 +: 32];
        end
      end
`endif
    end
  end

  assign rs1Ready       = lk_ready[0];
  assign rs2Ready       = lk_ready[1];
  assign rs1Value       = lk_value[0];
  assign rs2Value       = lk_value[1];

  assign clear          = clear_q;
  assign newPc          = new_pc_q;
  assign full           = (count_q >= FULL_C);
  assign next           = tail_q;
  assign robBeginId     = head_q;
  assign storeCommit    = store_commit_q;
  assign storeRobId     = store_rob_id_q;
  assign regUpdateValid = reg_update_valid_q;
  assign regUpdateDest  = reg_update_dest_q;
  assign regValue       = reg_value_q;
  assign regUpdateRobId = reg_update_rob_id_q;

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// tb_reorder_buffer_mc: directed self-checking bench for reorder_buffer_mc.
// Follows the ROB_FWD_EN macro for the same-cycle lookup expectations.
`timescale 1ns/100ps
module tb_reorder_buffer_mc;

  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear;
  logic [31:0]   new_pc;
  logic [1:0]    wb_valid = '0;
  logic [2*W-1:0] wb_rob_index = '0;
  logic [63:0]   wb_value = '0;
  logic          add_valid = 1'b0;
  logic [1:0]    add_type = '0;
  logic          add_ready = 1'b0;
  logic [31:0]   add_value = '0;
  logic          add_jump = 1'b0;
  logic [4:0]    add_dest = '0;
  logic [31:0]   add_addr = '0;
  logic          full;
  logic [W-1:0]  next;
  logic [W-1:0]  rob_begin_id;
  logic          store_commit;
  logic [W-1:0]  store_rob_id;
  logic          reg_update_valid;
  logic [4:0]    reg_update_dest;
  logic [31:0]   reg_value;
  logic [W-1:0]  reg_update_rob_id;
  logic [W-1:0]  rs1_dep = '0;
  logic [W-1:0]  rs2_dep = '0;
  logic          rs1_ready;
  logic          rs2_ready;
  logic [31:0]   rs1_value;
  logic [31:0]   rs2_value;

  int checks = 0;
  int errors = 0;

  reorder_buffer_mc #(.ROB_WIDTH(W), .NUM_WB(2), .FULL_MARGIN(2)) dut (
    .clockIn(clk), .resetIn(rst), .clear(clear), .newPc(new_pc),
    .wbValid(wb_valid), .wbRobIndex(wb_rob_index), .wbValue(wb_value),
    .addValid(add_valid), .addType(add_type), .addReady(add_ready),
    .addValue(add_value), .addJump(add_jump), .addDest(add_dest), .addAddr(add_addr),
    .full(full), .next(next), .robBeginId(rob_begin_id),
    .storeCommit(store_commit), .storeRobId(store_rob_id),
    .regUpdateValid(reg_update_valid), .regUpdateDest(reg_update_dest),
    .regValue(reg_value), .regUpdateRobId(reg_update_rob_id),
    .rs1Dep(rs1_dep), .rs2Dep(rs2_dep), .rs1Ready(rs1_ready), .rs2Ready(rs2_ready),
    .rs1Value(rs1_value), .rs2Value(rs2_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_add(input logic [1:0] t, input logic rdy, input logic [31:0] val,
                         input logic jmp, input logic [4:0] dst, input logic [31:0] adr);
    add_valid = 1'b1;
    add_type  = t;
    add_ready = rdy;
    add_value = val;
    add_jump  = jmp;
    add_dest  = dst;
    add_addr  = adr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_clear", clear, 0);
    check("rst_newpc", new_pc, 0);
    check("rst_rupd_valid", reg_update_valid, 0);
    check("rst_rupd_value", reg_value, 0);
    check("rst_store_commit", store_commit, 0);
    check("rst_next", next, 0);
    check("rst_head", rob_begin_id, 0);
    check("rst_full", full, 0);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    do_reset();
    check("rst_rupd_dest", reg_update_dest, 0);
    check("rst_rupd_robid", reg_update_rob_id, 0);
    check("rst_store_robid", store_rob_id, 0);
    check("rst_rs1_ready", rs1_ready, 0);

    // T1: three born-ready register writes retire on consecutive cycles
    set_add(2'b00, 1'b1, 32'd5, 1'b0, 5'd1, 32'h0);
    step();
    check("t1_next_after_first", next, 1);
    check("t1_no_early_retire", reg_update_valid, 0);
    set_add(2'b00, 1'b1, 32'd6, 1'b0, 5'd2, 32'h0);
    step();
    check("t1_r0_valid", reg_update_valid, 1);
    check("t1_r0_dest", reg_update_dest, 1);
    check("t1_r0_value", reg_value, 5);
    check("t1_r0_robid", reg_update_rob_id, 0);
    check("t1_r0_head", rob_begin_id, 1);
    set_add(2'b00, 1'b1, 32'd7, 1'b0, 5'd3, 32'h0);
    step();
    check("t1_r1_valid", reg_update_valid, 1);
    check("t1_r1_dest", reg_update_dest, 2);
    check("t1_r1_value", reg_value, 6);
    check("t1_r1_robid", reg_update_rob_id, 1);
    add_valid = 1'b0;
    step();
    check("t1_r2_valid", reg_update_valid, 1);
    check("t1_r2_dest", reg_update_dest, 3);
    check("t1_r2_value", reg_value, 7);
    check("t1_r2_robid", reg_update_rob_id, 2);
    check("t1_head_end", rob_begin_id, 3);
    check("t1_next_end", next, 3);
    step();
    check("t1_strobe_drop", reg_update_valid, 0);
    check("t1_empty_not_full", full, 0);

    // T2: fill all 16 entries, full at 14, 17th request dropped
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_add(2'b00, 1'b0, 32'(i), 1'b0, 5'(i + 1), 32'h0);
      step();
      if (i == 12) check("t2_full_at_13", full, 0);
      if (i == 13) check("t2_full_at_14", full, 1);
    end
    check("t2_next_wrapped", next, 0);
    step();
    check("t2_drop_next", next, 0);
    check("t2_drop_full", full, 1);
    check("t2_drop_head", rob_begin_id, 0);
    add_valid = 1'b0;
    rs1_dep = 4'd5;
    #1;
    check("t2_unready_lookup", rs1_ready, 0);

    // T3: dual writeback to the same index, highest channel wins
    rs1_dep = 4'd0;
    wb_valid = 2'b11;
    wb_rob_index = {4'd4, 4'd4};
    wb_value = {32'hB, 32'hA};
    step();
    wb_valid = 2'b00;
    rs1_dep = 4'd4;
    #1;
    check("t3_entry4_ready", rs1_ready, 1);
    check("t3_entry4_value", rs1_value, 32'hB);
    wb_valid = 2'b01;
    wb_rob_index = {4'd0, 4'd0};
    wb_value = {32'h0, 32'h10};
    step();
    wb_valid = 2'b00;
    #1;
    check("t3_wb_no_same_cycle_retire", reg_update_valid, 0);
    step();
    check("t3_retire_valid", reg_update_valid, 1);
    check("t3_retire_value", reg_value, 32'h10);
    check("t3_retire_dest", reg_update_dest, 1);
    check("t3_retire_robid", reg_update_rob_id, 0);
    check("t3_retire_head", rob_begin_id, 1);
    check("t3_retire_next", next, 0);
    check("t3_retire_full", full, 1);

    // T3b: writeback to an invalid entry is ignored
    do_reset();
    wb_valid = 2'b01;
    wb_rob_index = {4'd0, 4'd7};
    wb_value = {32'h0, 32'h77};
    step();
    wb_valid = 2'b00;
    rs1_dep = 4'd7;
    #1;
    check("t3b_invalid_ready", rs1_ready, 0);
    check("t3b_invalid_next", next, 0);
    check("t3b_invalid_retire", reg_update_valid, 0);

    // T4: mispredicted branch with two younger entries flushes and redirects
    do_reset();
    set_add(2'b01, 1'b0, 32'h0, 1'b1, 5'd0, 32'h100);
    step();
    set_add(2'b00, 1'b1, 32'h21, 1'b0, 5'd4, 32'h0);
    step();
    set_add(2'b00, 1'b1, 32'h22, 1'b0, 5'd5, 32'h0);
    step();
    add_valid = 1'b0;
    check("t4_next_before", next, 3);
    check("t4_no_retire_behind_branch", reg_update_valid, 0);
    wb_valid = 2'b01;
    wb_rob_index = {4'd0, 4'd0};
    wb_value = {32'h0, 32'h0};
    step();
    wb_valid = 2'b00;
    check("t4_clear_not_yet", clear, 0);
    set_add(2'b00, 1'b1, 32'h33, 1'b0, 5'd6, 32'h0);
    step();
    check("t4_clear", clear, 1);
    check("t4_newpc", new_pc, 32'h100);
    check("t4_next_zero", next, 0);
    check("t4_head_zero", rob_begin_id, 0);
    check("t4_not_full", full, 0);
    check("t4_no_rupd", reg_update_valid, 0);
    for (int i = 0; i < 16; i++) begin
      rs1_dep = 4'(i);
      #0.2;
      check($sformatf("t4_rs1_ready_tag%0d", i), rs1_ready, 0);
    end
    wb_valid = 2'b01;
    wb_rob_index = {4'd0, 4'd1};
    wb_value = {32'h0, 32'h1};
    step();
    check("t4_clear_one_cycle", clear, 0);
    check("t4_flush_alloc_lost", next, 0);
    check("t4_clear_cycle_no_rupd", reg_update_valid, 0);
    add_valid = 1'b0;
    wb_valid = 2'b00;

    // T5: correctly predicted branch retires silently, then a store is released
    set_add(2'b01, 1'b1, 32'h0, 1'b0, 5'd0, 32'h200);
    step();
    set_add(2'b10, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    add_valid = 1'b0;
    check("t5_branch_silent_clear", clear, 0);
    check("t5_branch_silent_rupd", reg_update_valid, 0);
    check("t5_branch_silent_store", store_commit, 0);
    check("t5_branch_head", rob_begin_id, 1);
    wb_valid = 2'b10;
    wb_rob_index = {4'd1, 4'd0};
    wb_value = {32'h99, 32'h0};
    step();
    wb_valid = 2'b00;
    check("t5_store_not_yet", store_commit, 0);
    step();
    check("t5_store_commit", store_commit, 1);
    check("t5_store_robid", store_rob_id, 1);
    check("t5_store_no_rupd", reg_update_valid, 0);
    step();
    check("t5_store_one_cycle", store_commit, 0);
    check("t5_store_head", rob_begin_id, 2);

    // T6: lookup of a tag written back in the same cycle
    set_add(2'b00, 1'b0, 32'h0, 1'b0, 5'd7, 32'h0);
    step();
    set_add(2'b00, 1'b0, 32'h0, 1'b0, 5'd8, 32'h0);
    step();
    add_valid = 1'b0;
    rs1_dep = 4'd3;
    rs2_dep = 4'd2;
    wb_valid = 2'b01;
    wb_rob_index = {4'd0, 4'd3};
    wb_value = {32'h0, 32'h55};
    #1;
`ifdef ROB_FWD_EN
    check("t6_fwd_ready", rs1_ready, 1);
    check("t6_fwd_value", rs1_value, 32'h55);
`else
    check("t6_nofwd_ready", rs1_ready, 0);
`endif
    check("t6_rs2_unready", rs2_ready, 0);
    step();
    wb_valid = 2'b00;
    #1;
    check("t6_stored_ready", rs1_ready, 1);
    check("t6_stored_value", rs1_value, 32'h55);
    wb_valid = 2'b10;
    wb_rob_index = {4'd2, 4'd0};
    wb_value = {32'h66, 32'h0};
    step();
    wb_valid = 2'b00;
    #1;
    check("t6_rs2_ready", rs2_ready, 1);
    check("t6_rs2_value", rs2_value, 32'h66);
    step();
    check("t6_retire_after_wb", reg_update_valid, 1);
    check("t6_retire_value", reg_value, 32'h66);
    check("t6_retire_robid", reg_update_rob_id, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
